// File: rtl/uvma_rvfi_pkg.sv
// Shared RVFI agent definitions: order width and retirement-scheduler types.
package uvma_rvfi_pkg;

    localparam int ORDER_WL              = 64;
    localparam int RETIRE_SCHED_MAX_NRET = 4;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        RESYNC
    } uvma_rvfi_retire_sched_state_t;

endpackage

// File: rtl/uvma_rvfi_retire_fifo.sv
// Single-clock FIFO with a combinational head, empty/full flags and occupancy count.
module uvma_rvfi_retire_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/uvma_rvfi_retire_sched.sv
// Merges NRET RVFI retirement channels into one in-order stream keyed on rvfi_order,
// with stall timeout/resync on order gaps and duplicate detection.
module uvma_rvfi_retire_sched
    import uvma_rvfi_pkg::*;
#(
    parameter int NRET          = 2,
    parameter int PAYLOAD_WL    = 256,
    parameter int DEPTH         = 4,
    parameter int FIRST_ORDER   = 1,
    parameter int STALL_TIMEOUT = 64,
    localparam int CHAN_WL      = (NRET > 1) ? $clog2(NRET) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NRET-1:0]            in_valid,
    output logic [NRET-1:0]            in_ready,
    input  logic [NRET*ORDER_WL-1:0]   in_order,
    input  logic [NRET*PAYLOAD_WL-1:0] in_payload,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ORDER_WL-1:0]        out_order,
    output logic [PAYLOAD_WL-1:0]      out_payload,
    output logic [CHAN_WL-1:0]         out_chan,
    output logic                       gap_err,
    output logic                       dup_err,
    input  logic                       err_clr,
    output logic [ORDER_WL-1:0]        retired_cnt
);

    localparam int STALL_WL = $clog2(STALL_TIMEOUT) + 1;
    localparam int ENTRY_WL = ORDER_WL + PAYLOAD_WL;

    uvma_rvfi_retire_sched_state_t state, state_nxt;

    logic [STALL_WL-1:0]   stall_cnt, stall_nxt;
    logic [ORDER_WL-1:0]   expected;
    logic                  ready_en;

    logic [NRET-1:0]       fifo_empty, fifo_full, push, pop, hit, sel_oh;
    logic [ENTRY_WL-1:0]   head_entry   [NRET];
    logic [ORDER_WL-1:0]   head_order   [NRET];
    logic [PAYLOAD_WL-1:0] head_payload [NRET];
    logic [$clog2(DEPTH):0] fifo_count  [NRET];

    logic                  match, multi, any_data, load, gap_set, min_found;
    logic [ORDER_WL-1:0]   min_order;
    logic [CHAN_WL-1:0]    sel_idx;
    logic [PAYLOAD_WL-1:0] sel_payload;

    // in_ready stays low until the first clock after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    assign in_ready = ready_en ? ~fifo_full : '0;
    assign push     = in_valid & in_ready;

    for (genvar g = 0; g < NRET; g++) begin : g_chan
        uvma_rvfi_retire_fifo #(
            .WIDTH (ENTRY_WL),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push[g]),
            .wdata   ({in_order[g*ORDER_WL +: ORDER_WL], in_payload[g*PAYLOAD_WL +: PAYLOAD_WL]}),
            .pop     (pop[g]),
            .head    (head_entry[g]),
            .empty   (fifo_empty[g]),
            .full    (fifo_full[g]),
            .count   (fifo_count[g])
        );
        assign head_order[g]   = head_entry[g][ENTRY_WL-1 -: ORDER_WL];
        assign head_payload[g] = head_entry[g][PAYLOAD_WL-1:0];
    end

    always_comb begin
        hit         = '0;
        any_data    = 1'b0;
        min_found   = 1'b0;
        min_order   = expected;
        sel_idx     = '0;
        sel_payload = '0;
        for (int unsigned i = 0; i < NRET; i++) begin
            hit[i] = !fifo_empty[i] && (head_order[i] == expected);
            if (fifo_count[i] != '0) begin
                any_data = 1'b1;
                if (!min_found || (head_order[i] < min_order)) begin
                    min_order = head_order[i];
                    min_found = 1'b1;
                end
            end
        end
        // Lowest set bit of hit picks the winning channel.
        sel_oh = hit & (~hit + NRET'(1));
        multi  = |(hit & (hit - NRET'(1)));
        match  = |hit;
        for (int unsigned i = 0; i < NRET; i++) begin
            if (sel_oh[i]) begin
                sel_idx     = CHAN_WL'(i);
                sel_payload = head_payload[i];
            end
        end
        load = (!out_valid || out_ready) && match && (state != RESYNC);
        pop  = load ? sel_oh : '0;
    end

    always_comb begin
        state_nxt = state;
        stall_nxt = stall_cnt;
        gap_set   = 1'b0;
        case (state)
            RUN: begin
                if (!match && any_data) begin
                    state_nxt = STALL;
                    stall_nxt = STALL_WL'(1);
                end else begin
                    stall_nxt = '0;
                end
            end
            STALL: begin
                if (match || !any_data) begin
                    state_nxt = RUN;
                    stall_nxt = '0;
                end else if (stall_cnt == STALL_WL'(STALL_TIMEOUT - 1)) begin
                    state_nxt = RESYNC;
                    gap_set   = 1'b1;
                end else begin
                    stall_nxt = stall_cnt + 1'b1;
                end
            end
            RESYNC: begin
                state_nxt = RUN;
                stall_nxt = '0;
            end
            default: begin
                state_nxt = RUN;
                stall_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            stall_cnt   <= '0;
            expected    <= ORDER_WL'(FIRST_ORDER);
            out_valid   <= 1'b0;
            out_order   <= '0;
            out_payload <= '0;
            out_chan    <= '0;
            retired_cnt <= '0;
            gap_err     <= 1'b0;
            dup_err     <= 1'b0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_nxt;
            if (state == RESYNC) begin
                if (min_found) expected <= min_order;
            end else if (load) begin
                expected <= expected + 1'b1;
            end
            if (load) begin
                out_valid   <= 1'b1;
                out_order   <= expected;
                out_payload <= sel_payload;
                out_chan    <= sel_idx;
                retired_cnt <= retired_cnt + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (gap_set)      gap_err <= 1'b1;
            else if (err_clr) gap_err <= 1'b0;
            if (load && multi) dup_err <= 1'b1;
            else if (err_clr)  dup_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uvma_rvfi_retire_sched.sv
// Scoreboard bench for uvma_rvfi_retire_sched: NRET=2, DEPTH=4, STALL_TIMEOUT=64.
module tb_uvma_rvfi_retire_sched;

    localparam int NRET = 2;
    localparam int PW   = 32;
    localparam int OW   = 64;

    typedef struct {
        logic [OW-1:0] order;
        logic [0:0]    chan;
        logic [PW-1:0] payload;
        int            cyc;
    } txn_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NRET-1:0]      in_valid = '0;
    logic [NRET-1:0]      in_ready;
    logic [NRET*OW-1:0]   in_order = '0;
    logic [NRET*PW-1:0]   in_payload = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [OW-1:0]        out_order;
    logic [PW-1:0]        out_payload;
    logic [0:0]           out_chan;
    logic                 gap_err;
    logic                 dup_err;
    logic                 err_clr = 1'b0;
    logic [OW-1:0]        retired_cnt;

    txn_t          exp_pool[$];
    txn_t          got_q[$];
    txn_t          mon_t;
    logic [OW-1:0] model_exp;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            push_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uvma_rvfi_retire_sched #(
        .NRET          (NRET),
        .PAYLOAD_WL    (PW),
        .DEPTH         (4),
        .FIRST_ORDER   (1),
        .STALL_TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_order    (in_order),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_order   (out_order),
        .out_payload (out_payload),
        .out_chan    (out_chan),
        .gap_err     (gap_err),
        .dup_err     (dup_err),
        .err_clr     (err_clr),
        .retired_cnt (retired_cnt)
    );

    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            mon_t.order   = out_order;
            mon_t.chan    = out_chan;
            mon_t.payload = out_payload;
            mon_t.cyc     = cyc;
            got_q.push_back(mon_t);
        end
    end

    function automatic logic [PW-1:0] pay(input logic [OW-1:0] o, input int ch);
        return (o[31:0] * 32'h9E3779B1) ^ ((ch == 1) ? 32'hA5A5_0000 : 32'h0000_5A5A);
    endfunction

    // Called at posedge+1; presents one beat and returns at the next posedge+1.
    task automatic drive(input logic [1:0] v, input logic [OW-1:0] o0, input logic [OW-1:0] o1);
        txn_t t;
        in_valid   = v;
        in_order   = {o1, o0};
        in_payload = {pay(o1, 1), pay(o0, 0)};
        if (v[0] && in_ready[0]) begin
            t.order = o0; t.chan = 1'b0; t.payload = pay(o0, 0); t.cyc = 0;
            exp_pool.push_back(t);
        end
        if (v[1] && in_ready[1]) begin
            t.order = o1; t.chan = 1'b1; t.payload = pay(o1, 1); t.cyc = 0;
            exp_pool.push_back(t);
        end
        @(posedge clk); #1;
        push_cyc = cyc;
        in_valid = '0;
    endtask

    task automatic get_out(output txn_t g, output bit ok);
        int n = 0;
        while (got_q.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (got_q.size() != 0);
        if (ok) g = got_q.pop_front();
        else    g = '{default: 0};
    endtask

    // Reference model: next in-order entry is the lowest channel holding model_exp.
    task automatic exp_next(output txn_t e, output bit ok);
        int idx = -1;
        for (int i = 0; i < exp_pool.size(); i++) begin
            if (exp_pool[i].order == model_exp && (idx < 0 || exp_pool[i].chan < exp_pool[idx].chan))
                idx = i;
        end
        ok = (idx >= 0);
        if (ok) begin
            e = exp_pool[idx];
            exp_pool.delete(idx);
            model_exp = model_exp + 1;
        end else begin
            e = '{default: 0};
        end
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({out_valid, in_ready, gap_err, dup_err} !== 5'b0 || retired_cnt !== '0 || out_order !== '0) begin
            bad++;
            $display("FAIL reset_state: valid=%b ready=%b gap=%b dup=%b ret=%0d order=%0d, want all 0",
                     out_valid, in_ready, gap_err, dup_err, retired_cnt, out_order);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 2'b00) begin
            bad++;
            $display("FAIL ready_at_release: got=%b want=00", in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (in_ready !== 2'b11) begin
            bad++;
            $display("FAIL ready_after_release: got=%b want=11", in_ready);
        end
        model_exp = 1;
    endtask

    task automatic test_interleave();
        txn_t g, e;
        bit gok, eok;
        int c0;
        drive(2'b11, 1, 2);
        c0 = push_cyc;
        drive(2'b11, 3, 4);
        drive(2'b11, 5, 6);
        for (int k = 0; k < 6; k++) begin
            get_out(g, gok);
            exp_next(e, eok);
            total++;
            if (!gok || !eok || g.order !== e.order || g.chan !== e.chan || g.payload !== e.payload || g.cyc != c0 + 1 + k) begin
                bad++;
                $display("FAIL interleave[%0d]: got order=%0d chan=%0d pay=%h cyc=%0d, want order=%0d chan=%0d pay=%h cyc=%0d",
                         k, g.order, g.chan, g.payload, g.cyc, e.order, e.chan, e.payload, c0 + 1 + k);
            end
        end
        total++;
        if (retired_cnt !== 64'd6) begin
            bad++;
            $display("FAIL retired_after_interleave: got=%0d want=6", retired_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_order();
        txn_t g, e;
        bit gok, eok;
        drive(2'b10, 0, 8);
        drive(2'b10, 0, 9);
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_until_first: out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        drive(2'b01, 7, 0);
        for (int k = 0; k < 3; k++) begin
            get_out(g, gok);
            exp_next(e, eok);
            total++;
            if (!gok || !eok || g.order !== e.order || g.chan !== e.chan || g.payload !== e.payload) begin
                bad++;
                $display("FAIL out_of_order[%0d]: got order=%0d chan=%0d, want order=%0d chan=%0d",
                         k, g.order, g.chan, e.order, e.chan);
            end
        end
        total++;
        if (gap_err !== 1'b0) begin
            bad++;
            $display("FAIL no_gap_reorder: gap_err=%b want 0", gap_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        txn_t g, e;
        bit gok, eok;
        out_ready = 1'b0;
        drive(2'b11, 10, 11);
        drive(2'b11, 12, 13);
        drive(2'b11, 14, 15);
        drive(2'b11, 16, 17);
        total++;
        if (in_ready !== 2'b01) begin
            bad++;
            $display("FAIL ready_ch1_full: got=%b want=01", in_ready);
        end
        drive(2'b01, 18, 0);
        total++;
        if (in_ready !== 2'b00) begin
            bad++;
            $display("FAIL ready_both_full: got=%b want=00", in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_order !== 64'd10 || out_payload !== pay(10, 0)) begin
                bad++;
                $display("FAIL stall_hold[%0d]: valid=%b order=%0d pay=%h, want 1/10/%h",
                         k, out_valid, out_order, out_payload, pay(10, 0));
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            get_out(g, gok);
            exp_next(e, eok);
            total++;
            if (!gok || !eok || g.order !== e.order || g.chan !== e.chan || g.payload !== e.payload) begin
                bad++;
                $display("FAIL backpressure[%0d]: got order=%0d chan=%0d, want order=%0d chan=%0d",
                         k, g.order, g.chan, e.order, e.chan);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gap();
        txn_t g, e;
        bit gok, eok;
        int c0, gap_cyc;
        drive(2'b01, 23, 0);
        c0 = push_cyc;
        gap_cyc = -1;
        for (int n = 0; n < 200 && gap_cyc < 0; n++) begin
            @(negedge clk);
            if (gap_err === 1'b1) gap_cyc = cyc;
        end
        total++;
        if (gap_cyc != c0 + 64 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL gap_timeout: gap seen at cyc=%0d valid=%b, want cyc=%0d valid=0", gap_cyc, out_valid, c0 + 64);
        end
        model_exp = 23;
        get_out(g, gok);
        exp_next(e, eok);
        total++;
        if (!gok || !eok || g.order !== e.order || g.payload !== e.payload || g.cyc != c0 + 66) begin
            bad++;
            $display("FAIL gap_resync: got order=%0d cyc=%0d, want order=%0d cyc=%0d", g.order, g.cyc, e.order, c0 + 66);
        end
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        total++;
        if (gap_err !== 1'b0) begin
            bad++;
            $display("FAIL gap_clear: gap_err=%b want 0", gap_err);
        end
    endtask

    task automatic test_dup();
        txn_t g, e;
        bit gok, eok;
        bit seen;
        model_exp = 24;
        drive(2'b11, 24, 24);
        get_out(g, gok);
        exp_next(e, eok);
        total++;
        if (!gok || !eok || g.order !== e.order || g.chan !== e.chan || g.payload !== e.payload) begin
            bad++;
            $display("FAIL dup_first: got order=%0d chan=%0d, want order=%0d chan=%0d", g.order, g.chan, e.order, e.chan);
        end
        total++;
        if (dup_err !== 1'b1) begin
            bad++;
            $display("FAIL dup_flag: dup_err=%b want 1", dup_err);
        end
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (gap_err === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL dup_gap: gap_err=%b want 1 within 200 cycles", gap_err);
        end
        model_exp = 24;
        get_out(g, gok);
        exp_next(e, eok);
        total++;
        if (!gok || !eok || g.order !== e.order || g.chan !== e.chan || g.payload !== e.payload) begin
            bad++;
            $display("FAIL dup_second: got order=%0d chan=%0d, want order=%0d chan=%0d", g.order, g.chan, e.order, e.chan);
        end
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        total++;
        if (gap_err !== 1'b0 || dup_err !== 1'b0) begin
            bad++;
            $display("FAIL dup_clear: gap=%b dup=%b want 0/0", gap_err, dup_err);
        end
    endtask

    task automatic test_reset_mid();
        txn_t g, e;
        bit gok, eok;
        out_ready = 1'b0;
        model_exp = 25;
        drive(2'b11, 25, 26);
        drive(2'b11, 27, 28);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 2'b00 || retired_cnt !== '0) begin
            bad++;
            $display("FAIL async_reset: valid=%b ready=%b ret=%0d, want 0/00/0", out_valid, in_ready, retired_cnt);
        end
        exp_pool.delete();
        got_q.delete();
        model_exp = 1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(2'b10, 0, 1);
        get_out(g, gok);
        exp_next(e, eok);
        total++;
        if (!gok || !eok || g.order !== e.order || g.chan !== e.chan || g.payload !== e.payload) begin
            bad++;
            $display("FAIL post_reset_first: got order=%0d chan=%0d, want order=%0d chan=%0d", g.order, g.chan, e.order, e.chan);
        end
        total++;
        if (retired_cnt !== 64'd1) begin
            bad++;
            $display("FAIL post_reset_retired: got=%0d want=1", retired_cnt);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_interleave();
        test_out_of_order();
        test_backpressure();
        test_gap();
        test_dup();
        test_reset_mid();
        total++;
        if (got_q.size() != 0 || exp_pool.size() != 0) begin
            bad++;
            $display("FAIL leftover: extra outputs=%0d unemitted=%0d, want 0/0", got_q.size(), exp_pool.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
